// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between the MA stage and a debug/loader master
// Grants are combinational from the requests in IDLE; reads park in RD_WAIT until the data returns.
module dmem_port_arbiter #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int RD_LATENCY     = 1,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ma_req,
  input  logic                      ma_we,
  input  logic [MEM_ADDR_WIDTH-1:0] ma_addr,
  input  logic [MEM_DATA_WIDTH-1:0] ma_wdata,
  output logic                      ma_gnt,
  output logic                      ma_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] ma_rdata,
  output logic                      ma_stall,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  input  logic [MEM_DATA_WIDTH-1:0] dbg_wdata,
  output logic                      dbg_gnt,
  output logic                      dbg_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] dbg_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_waddr,
  output logic [MEM_DATA_WIDTH-1:0] dmem_wdata,
  output logic                      dmem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_raddr,
  output logic                      dmem_ren,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;   // 1 = debug master owns the outstanding read
  logic [1:0] wait_q, wait_d;
  logic [3:0] streak_q, streak_d;

  logic                      in_idle, dbg_win, ma_win, any_win, rd_done;
  logic                      win_we;
  logic [MEM_ADDR_WIDTH-1:0] win_addr;
  logic [MEM_DATA_WIDTH-1:0] win_wdata;

  // Outputs must read 0 while rst is high, so every decode is gated by it.
  assign in_idle   = (state_q == IDLE) && !rst;
  assign dbg_win   = in_idle && dbg_req && (!ma_req || streak_q == LIMIT);
  assign ma_win    = in_idle && ma_req && !dbg_win;
  assign any_win   = dbg_win || ma_win;
  assign rd_done   = (state_q == RD_WAIT) && (wait_q == 2'd0) && !rst;
  assign win_we    = dbg_win ? dbg_we : ma_we;
  assign win_addr  = dbg_win ? dbg_addr : ma_addr;
  assign win_wdata = dbg_win ? dbg_wdata : ma_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wait_q   <= 2'd0;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wait_q   <= wait_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wait_d   = wait_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (any_win && !win_we) begin
          state_d = RD_WAIT;
          owner_d = dbg_win;
          wait_d  = WAIT_INIT;
        end
      end
      RD_WAIT: begin
        if (wait_q == 2'd0) state_d = IDLE;
        else                wait_d  = wait_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
    // The streak only means something while debug is actually waiting.
    if (!dbg_req || dbg_win)              streak_d = 4'd0;
    else if (ma_win && streak_q != LIMIT) streak_d = streak_q + 4'd1;
  end

  always_comb begin
    ma_gnt     = ma_win;
    dbg_gnt    = dbg_win;
    dmem_wen   = 1'b0;
    dmem_waddr = '0;
    dmem_wdata = '0;
    dmem_ren   = 1'b0;
    dmem_raddr = '0;
    ma_rvalid  = 1'b0;
    ma_rdata   = '0;
    dbg_rvalid = 1'b0;
    dbg_rdata  = '0;
    if (any_win) begin
      if (win_we) begin
        dmem_wen   = 1'b1;
        dmem_waddr = win_addr;
        dmem_wdata = win_wdata;
      end else begin
        dmem_ren   = 1'b1;
        dmem_raddr = win_addr;
      end
    end
    if (rd_done) begin
      if (owner_q) begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = dmem_rdata;
      end else begin
        ma_rvalid  = 1'b1;
        ma_rdata   = dmem_rdata;
      end
    end
    ma_stall = !rst && ((ma_req && !ma_win) ||
                        (state_q == RD_WAIT && !owner_q && !rd_done));
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed bench with a cycle-level reference model of the arbiter
module tb_dmem_port_arbiter;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ma_req = 1'b0, ma_we = 1'b0;
  logic [11:0] ma_addr = '0;
  logic [31:0] ma_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [11:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        ma_gnt, ma_rvalid, ma_stall, dbg_gnt, dbg_rvalid, dmem_wen, dmem_ren;
  logic [31:0] ma_rdata, dbg_rdata, dmem_wdata, dmem_rdata;
  logic [11:0] dmem_waddr, dmem_raddr;

  dmem_port_arbiter #(.MEM_ADDR_WIDTH(12), .MEM_DATA_WIDTH(32), .RD_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata), .ma_stall(ma_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen),
    .dmem_raddr(dmem_raddr), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tcyc  = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, tcyc, act, exp);
    end
  endtask

  // Memory device seen by the DUT: synchronous write, read data LAT cycles after ren.
  logic [31:0] dev_mem [4096];
  logic [11:0] pa [LAT];
  logic        pv [LAT];
  always @(posedge clk) begin
    if (dmem_wen) dev_mem[dmem_waddr] <= dmem_wdata;
    pa[0] <= dmem_raddr;
    pv[0] <= dmem_ren;
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pv[k] <= pv[k-1];
    end
  end
  assign dmem_rdata = pv[LAT-1] ? dev_mem[pa[LAT-1]] : 32'hBAD0BAD0;

  // Reference model: one outstanding read tracked by its return cycle number.
  logic [31:0] mmem [4096];
  int          ret_cyc = -1;
  bit          ret_dbg;
  logic [31:0] ret_dat;
  int          streak = 0;

  always @(negedge clk) begin : model
    bit          busy, mw, dw, gw;
    logic [11:0] ga;
    logic [31:0] gd;
    bit          e_mg, e_dg, e_mrv, e_drv, e_wen, e_ren, e_st;
    logic [31:0] e_mrd, e_drd, e_wd;
    logic [11:0] e_wa, e_ra;
    busy = 0; mw = 0; dw = 0;
    e_mg = 0; e_dg = 0; e_mrv = 0; e_drv = 0; e_wen = 0; e_ren = 0; e_st = 0;
    e_mrd = '0; e_drd = '0; e_wd = '0; e_wa = '0; e_ra = '0;
    gw = dbg_req && (!ma_req || streak == SL) ? dbg_we : ma_we;
    ga = '0; gd = '0;
    if (!rst) begin
      busy = ret_cyc >= 0;
      if (busy) begin
        if (tcyc == ret_cyc) begin
          if (ret_dbg) begin e_drv = 1; e_drd = ret_dat; end
          else begin e_mrv = 1; e_mrd = ret_dat; end
        end
      end else begin
        dw = dbg_req && (!ma_req || streak == SL);
        mw = ma_req && !dw;
      end
      gw = dw ? dbg_we : ma_we;
      ga = dw ? dbg_addr : ma_addr;
      gd = dw ? dbg_wdata : ma_wdata;
      e_mg = mw; e_dg = dw;
      if (mw || dw) begin
        if (gw) begin e_wen = 1; e_wa = ga; e_wd = gd; end
        else begin e_ren = 1; e_ra = ga; end
      end
      e_st = (ma_req && !mw) || (busy && !ret_dbg && !e_mrv);
    end
    chk("ma_gnt", 32'(ma_gnt), 32'(e_mg));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
    chk("ma_rvalid", 32'(ma_rvalid), 32'(e_mrv));
    chk("ma_rdata", ma_rdata, e_mrd);
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv));
    chk("dbg_rdata", dbg_rdata, e_drd);
    chk("ma_stall", 32'(ma_stall), 32'(e_st));
    chk("dmem_wen", 32'(dmem_wen), 32'(e_wen));
    chk("dmem_waddr", 32'(dmem_waddr), 32'(e_wa));
    chk("dmem_wdata", dmem_wdata, e_wd);
    chk("dmem_ren", 32'(dmem_ren), 32'(e_ren));
    chk("dmem_raddr", 32'(dmem_raddr), 32'(e_ra));
    if (rst) begin
      ret_cyc = -1;
      streak  = 0;
    end else begin
      if (busy && tcyc == ret_cyc) ret_cyc = -1;
      if (mw || dw) begin
        if (gw) mmem[ga] = gd;
        else begin ret_cyc = tcyc + LAT; ret_dbg = dw; ret_dat = mmem[ga]; end
      end
      if (!dbg_req || dw) streak = 0;
      else if (mw && streak < SL) streak++;
    end
  end

  // Event recorder for the hand-computed checks.
  int          ma_rv_cnt = 0, last_dbg_rv_cyc = -1;
  logic [31:0] last_ma_rd = '0, last_dbg_rd = '0;
  bit          log_en = 0;
  string       glog = "";
  always @(negedge clk) begin
    if (ma_rvalid) begin ma_rv_cnt++; last_ma_rd = ma_rdata; end
    if (dbg_rvalid) begin last_dbg_rv_cyc = tcyc; last_dbg_rd = dbg_rdata; end
    if (log_en && ma_gnt) glog = {glog, "M"};
    if (log_en && dbg_gnt) glog = {glog, "D"};
  end

  logic        g_wen, g_ren, g_other, g_stall;
  logic [11:0] g_waddr;
  logic [31:0] g_wdata;

  // Call just after a rising edge; returns just after the edge following the grant.
  task automatic access(input bit dbg, input bit we, input logic [11:0] a, input logic [31:0] d,
                        input bit keep, output int gc);
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else begin ma_req = 1; ma_we = we; ma_addr = a; ma_wdata = d; end
    gc = -1;
    for (int i = 0; i < 40 && gc < 0; i++) begin
      @(negedge clk);
      if (dbg ? dbg_gnt : ma_gnt) begin
        gc = tcyc; g_wen = dmem_wen; g_ren = dmem_ren; g_waddr = dmem_waddr;
        g_wdata = dmem_wdata; g_other = dbg ? ma_gnt : dbg_gnt; g_stall = ma_stall;
      end
    end
    if (gc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: %s got no grant, required one within 40 cycles", dbg ? "dbg" : "ma");
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (dbg) begin dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; end
      else begin ma_req = 0; ma_we = 0; ma_addr = '0; ma_wdata = '0; end
    end
  endtask

  initial begin
    int gc, gc2, gd, gm, rc, snap;
    for (int i = 0; i < 4096; i++) begin
      dev_mem[i] = 32'(i) * 32'h9E3779B1;
      mmem[i]    = 32'(i) * 32'h9E3779B1;
    end
    dev_mem[12'h010] = 32'hCAFE0001; mmem[12'h010] = 32'hCAFE0001;
    dev_mem[12'h003] = 32'h0BADF00D; mmem[12'h003] = 32'h0BADF00D;

    // Reset: a request while rst is high must see no grant and no stall.
    ma_req = 1;
    @(negedge clk);
    chk("rst_ma_gnt", 32'(ma_gnt), 32'd0);
    chk("rst_ma_stall", 32'(ma_stall), 32'd0);
    @(posedge clk); #1; ma_req = 0;
    @(posedge clk); #1; rst = 0;
    repeat (2) @(posedge clk); #1;

    // MA load, two-cycle latency.
    access(0, 0, 12'h010, '0, 0, gc);
    @(negedge clk);
    chk("t1_stall_wait", 32'(ma_stall), 32'd1);
    chk("t1_no_rvalid_early", 32'(ma_rvalid), 32'd0);
    @(negedge clk);
    chk("t1_rvalid", 32'(ma_rvalid), 32'd1);
    chk("t1_rdata", ma_rdata, 32'hCAFE0001);
    @(posedge clk); #1;

    // MA store completes in its grant cycle; a read right behind it is granted next cycle.
    access(0, 1, 12'h020, 32'h12345678, 0, gc);
    chk("t2_wen", 32'(g_wen), 32'd1);
    chk("t2_waddr", 32'(g_waddr), 32'h020);
    chk("t2_wdata", g_wdata, 32'h12345678);
    chk("t2_stall", 32'(g_stall), 32'd0);
    access(0, 0, 12'h020, '0, 0, gc2);
    chk("t2_back_to_back", 32'(gc2 - gc), 32'd1);
    repeat (2) @(negedge clk); #1;
    chk("t2_readback", last_ma_rd, 32'h12345678);
    @(posedge clk); #1;

    // Both masters hammering writes: debug gets a slot after every SL MA grants.
    glog = ""; log_en = 1;
    fork
      begin
        int g1;
        for (int i = 0; i < 8; i++) access(0, 1, 12'h100 + 12'(i), 32'(i), i < 7, g1);
      end
      begin
        int g2;
        for (int i = 0; i < 2; i++) access(1, 1, 12'h200 + 12'(i), ~32'(i), i < 1, g2);
      end
    join
    log_en = 0;
    n_cmp++;
    if (glog != "MMMMDMMMMD") begin
      n_bad++;
      $display("FAIL t3_pattern: got %s expected MMMMDMMMMD", glog);
    end
    @(posedge clk); #1;

    // Debug read in flight blocks MA until the cycle after its data returns.
    snap = ma_rv_cnt;
    access(1, 0, 12'h003, '0, 0, gd);
    access(0, 0, 12'h040, '0, 0, gm);
    chk("t4_dbg_rv_cycle", 32'(last_dbg_rv_cyc - gd), 32'(LAT));
    chk("t4_dbg_rdata", last_dbg_rd, 32'h0BADF00D);
    chk("t4_ma_gnt_cycle", 32'(gm - gd), 32'(LAT + 1));
    chk("t4_no_ma_rvalid", 32'(ma_rv_cnt), 32'(snap));
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of an MA read aborts it.
    access(0, 0, 12'h010, '0, 0, gc);
    rst = 1;
    @(negedge clk);
    chk("t5_stall_in_rst", 32'(ma_stall), 32'd0);
    snap = ma_rv_cnt;
    @(posedge clk); #1; rst = 0;
    repeat (4) @(negedge clk); #1;
    chk("t5_no_rvalid", 32'(ma_rv_cnt), 32'(snap));
    @(posedge clk); #1;
    rc = tcyc;
    access(0, 0, 12'h010, '0, 0, gc);
    chk("t5_regrant", 32'(gc), 32'(rc));
    repeat (3) @(posedge clk); #1;

    // Lone debug write at the top address, then read it back.
    access(1, 1, 12'hFFF, 32'hDEADBEEF, 0, gc);
    chk("t6_wen", 32'(g_wen), 32'd1);
    chk("t6_waddr", 32'(g_waddr), 32'hFFF);
    chk("t6_wdata", g_wdata, 32'hDEADBEEF);
    chk("t6_ma_gnt", 32'(g_other), 32'd0);
    access(1, 0, 12'hFFF, '0, 0, gc);
    repeat (2) @(negedge clk); #1;
    chk("t6_readback", last_dbg_rd, 32'hDEADBEEF);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
